// File: rtl/eer_rl_pkg.sv
// Shared types and constants for the EER-RL cluster-head heartbeat blocks.
package eer_rl_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int SEQ_WIDTH  = 8;
  localparam int PKT_WORDS  = 5;

  localparam logic [7:0]            HB_TYPE = 8'h02;
  localparam logic [WORD_WIDTH-1:0] NO_CH   = 16'hFFFF;
  // Relayed hop count never reaches NO_CH, so receivers can't mistake it for "no CH".
  localparam logic [WORD_WIDTH-1:0] HOP_MAX = 16'hFFFE;

  typedef logic [2:0] hb_word_idx_t;
  localparam hb_word_idx_t LAST_IDX = 3'd4;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} hbtx_state_t;

  typedef struct packed {
    logic                  is_ch;
    logic [WORD_WIDTH-1:0] node_id;
    logic [WORD_WIDTH-1:0] q_value;
    logic [WORD_WIDTH-1:0] chosen_ch;
    logic [WORD_WIDTH-1:0] hops;
    logic [SEQ_WIDTH-1:0]  seq;
  } hb_fields_t;

  typedef logic [PKT_WORDS-1:0][WORD_WIDTH-1:0] hb_pkt_t;

  function automatic logic [WORD_WIDTH-1:0] hop_inc(input logic [WORD_WIDTH-1:0] h);
    return (h >= HOP_MAX) ? HOP_MAX : h + 16'd1;
  endfunction
endpackage

// File: rtl/hb_pkt_builder.sv
// Combinational HB packet image: header, advertised CH, hop count, Q-value, XOR checksum.
module hb_pkt_builder
  import eer_rl_pkg::*;
(
  input  hb_fields_t fields,
  output hb_pkt_t    words
);
  logic [WORD_WIDTH-1:0] w0, w1, w2, w3;

  assign w0 = {HB_TYPE, fields.seq};
  // A CH advertises itself at distance 0; a member relays its CH one hop further.
  assign w1 = fields.is_ch ? fields.node_id : fields.chosen_ch;
  assign w2 = fields.is_ch ? '0 : hop_inc(fields.hops);
  assign w3 = fields.q_value;

  assign words = {w0 ^ w1 ^ w2 ^ w3, w3, w2, w1, w0};
endmodule

// File: rtl/ch_heartbeat_tx.sv
// HB transmitter: per-round budget check, 5-word packet latch, valid/ready streamer.
module ch_heartbeat_tx
  import eer_rl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_HBTX,
  input  logic                  send_req,
  input  logic                  round_reset,
  input  logic                  is_CH,
  input  logic [WORD_WIDTH-1:0] node_ID,
  input  logic [WORD_WIDTH-1:0] node_QValue,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsfromCH,
  input  logic [WORD_WIDTH-1:0] HB_limit,
  input  logic                  pkt_ready,
  output logic [WORD_WIDTH-1:0] pkt_data,
  output logic                  pkt_valid,
  output logic                  pkt_last,
  output logic                  busy,
  output logic                  done,
  output logic                  req_drop,
  output logic [WORD_WIDTH-1:0] hb_count
);
  hbtx_state_t                            state;
  logic [SEQ_WIDTH-1:0]                   seq;
  hb_word_idx_t                           idx, nxt_idx;
  logic [PKT_WORDS-1:1][WORD_WIDTH-1:0]   pkt_buf;
  hb_pkt_t                                pkt_next;
  hb_fields_t                             fields;
  logic                                   eligible, hs;

  assign fields = '{is_ch: is_CH, node_id: node_ID, q_value: node_QValue,
                    chosen_ch: chosenCH, hops: hopsfromCH, seq: seq};

  hb_pkt_builder u_builder (.fields(fields), .words(pkt_next));

  assign eligible = (hb_count < HB_limit) && (is_CH || (hopsfromCH != NO_CH));
  assign hs       = pkt_valid && pkt_ready;
  assign nxt_idx  = idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      seq       <= '0;
      idx       <= '0;
      pkt_buf   <= '0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      pkt_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_drop  <= 1'b0;
      hb_count  <= '0;
    end else begin
      done     <= 1'b0;
      req_drop <= 1'b0;
      if (round_reset) hb_count <= '0;
      case (state)
        IDLE: if (send_req && en_HBTX) begin
          if (eligible) begin
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            req_drop <= 1'b1;
          end
        end
        LOAD: begin
          // Word 0 goes straight out; the rest wait in the buffer so mid-packet
          // input changes cannot leak into the stream.
          pkt_buf   <= pkt_next[PKT_WORDS-1:1];
          pkt_data  <= pkt_next[0];
          pkt_valid <= 1'b1;
          pkt_last  <= 1'b0;
          idx       <= '0;
          state     <= SEND;
        end
        SEND: if (hs) begin
          if (idx == LAST_IDX) begin
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx      <= nxt_idx;
            pkt_data <= pkt_buf[nxt_idx];
            pkt_last <= (nxt_idx == LAST_IDX);
          end
        end
        DONE: begin
          // A round boundary landing here still credits this packet to the new round.
          if (round_reset)           hb_count <= 16'd1;
          else if (hb_count != NO_CH) hb_count <= hb_count + 16'd1;
          seq   <= seq + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ch_heartbeat_tx.sv
// Directed bench for ch_heartbeat_tx with a transaction-level model checked every cycle.
module tb_ch_heartbeat_tx;
  logic        clk = 1'b0;
  logic        rst, en_HBTX, send_req, round_reset, is_CH;
  logic [15:0] node_ID, node_QValue, chosenCH, hopsfromCH, HB_limit;
  logic        pkt_ready = 1'b1;
  logic [15:0] pkt_data, hb_count;
  logic        pkt_valid, pkt_last, busy, done, req_drop;

  ch_heartbeat_tx dut (
    .clk(clk), .rst(rst), .en_HBTX(en_HBTX), .send_req(send_req), .round_reset(round_reset),
    .is_CH(is_CH), .node_ID(node_ID), .node_QValue(node_QValue), .chosenCH(chosenCH),
    .hopsfromCH(hopsfromCH), .HB_limit(HB_limit), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .pkt_valid(pkt_valid), .pkt_last(pkt_last), .busy(busy), .done(done), .req_drop(req_drop),
    .hb_count(hb_count)
  );

  always #5 clk = ~clk;

  // stimulus-side expectations
  logic [15:0] exp_mem [0:255];
  int          wr_ptr;
  bit          acc_pulse, exp_drop, tmo, bp_mode;
  // model state, owned by the compare process
  int          rd_ptr, n_chk, n_err;
  logic [15:0] m_count;
  logic [7:0]  m_seq;
  bit          m_valid, m_busy, m_done, p_last, p_rr, p_acc, pinned, tmo_seen, hs;

  bit [3:0] bp_pat = 4'b1001;
  int       bp_k;
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      pkt_ready = bp_pat[bp_k];
      bp_k = (bp_k + 1) % 4;
    end else pkt_ready = 1'b1;
  end

  function automatic logic [79:0] model_pkt(input bit ch, input logic [15:0] id, q, cid, hops,
                                            input logic [7:0] sq);
    logic [15:0] w [5];
    w[0] = {8'h02, sq};
    w[1] = ch ? id : cid;
    if (ch)                   w[2] = 16'h0000;
    else if (hops >= 16'hFFFE) w[2] = 16'hFFFE;
    else                      w[2] = hops + 16'd1;
    w[3] = q;
    w[4] = w[0] ^ w[1] ^ w[2] ^ w[3];
    return {w[4], w[3], w[2], w[1], w[0]};
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!pinned) begin
      pinned = 1'b1;
      chk("model_ch",    model_pkt(1'b1, 16'h0007, 16'h0123, 16'h0, 16'h0, 8'h00),
          80'h0324_0123_0000_0007_0200);
      chk("model_relay", model_pkt(1'b0, 16'h0009, 16'h0123, 16'h0003, 16'h0002, 8'h01),
          80'h0322_0123_0003_0003_0201);
      chk("model_sat",   model_pkt(1'b0, 16'h0009, 16'h0000, 16'h0003, 16'hFFFE, 8'h00),
          80'hFDFD_0000_FFFE_0003_0200);
    end
    if (tmo && !tmo_seen) begin
      tmo_seen = 1'b1;
      chk("timeout", 80'(1), 80'(0));
    end
    if (rst) begin
      m_count = 16'h0; m_seq = 8'h0; m_valid = 0; m_busy = 0; m_done = 0;
      p_last = 0; p_rr = 0; p_acc = 0; rd_ptr = wr_ptr;
      chk("rst_valid", 80'(pkt_valid), 80'(0));
      chk("rst_last",  80'(pkt_last),  80'(0));
      chk("rst_data",  80'(pkt_data),  80'(0));
      chk("rst_busy",  80'(busy),      80'(0));
      chk("rst_done",  80'(done),      80'(0));
      chk("rst_drop",  80'(req_drop),  80'(0));
      chk("rst_count", 80'(hb_count),  80'(0));
    end else begin
      // effects of the clock edge just passed
      if (m_done) begin
        m_count = p_rr ? 16'd1 : (m_count == 16'hFFFF ? m_count : m_count + 16'd1);
        m_seq   = m_seq + 8'd1;
      end else if (p_rr) m_count = 16'h0;
      m_done = p_last;
      if (p_last) begin m_valid = 0; m_busy = 0; end
      if (p_acc) m_valid = 1;
      if (acc_pulse) m_busy = 1;

      chk("valid", 80'(pkt_valid), 80'(m_valid));
      chk("busy",  80'(busy),      80'(m_busy));
      chk("done",  80'(done),      80'(m_done));
      chk("drop",  80'(req_drop),  80'(exp_drop));
      chk("count", 80'(hb_count),  80'(m_count));
      if (m_valid) begin
        chk("data", 80'(pkt_data), 80'(exp_mem[8'(rd_ptr)]));
        chk("last", 80'(pkt_last), 80'(rd_ptr % 5 == 4));
      end
      hs     = m_valid && pkt_ready;
      p_last = hs && (rd_ptr % 5 == 4);
      if (hs) rd_ptr++;
      p_rr  = round_reset;
      p_acc = acc_pulse;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((m_valid || m_busy || m_done || rd_ptr != wr_ptr) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) tmo = 1'b1;
  endtask

  task automatic req();
    bit          acc;
    logic [79:0] p;
    wait_idle();
    acc = en_HBTX && (m_count < HB_limit) && (is_CH || hopsfromCH != 16'hFFFF);
    if (acc) begin
      p = model_pkt(is_CH, node_ID, node_QValue, chosenCH, hopsfromCH, m_seq);
      for (int k = 0; k < 5; k++) exp_mem[8'(wr_ptr + k)] = p[k*16 +: 16];
      wr_ptr += 5;
    end
    send_req = 1'b1;
    @(posedge clk); #1;
    send_req = 1'b0;
    if (acc) acc_pulse = 1'b1; else exp_drop = en_HBTX;
    @(posedge clk); #1;
    acc_pulse = 1'b0;
    exp_drop  = 1'b0;
  endtask

  task automatic pulse_rr();
    round_reset = 1'b1;
    @(posedge clk); #1;
    round_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; en_HBTX = 1'b1; send_req = 1'b0; round_reset = 1'b0; is_CH = 1'b1;
    node_ID = 16'h0007; node_QValue = 16'h0123; chosenCH = 16'h0; hopsfromCH = 16'hFFFF;
    HB_limit = 16'hFFFF; wr_ptr = 0; acc_pulse = 0; exp_drop = 0; tmo = 0; bp_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // CH advertisement
    req(); wait_idle();
    // member relay; enable dropped mid-packet must not cut it short
    is_CH = 1'b0; chosenCH = 16'h0003; hopsfromCH = 16'h0002;
    req(); en_HBTX = 1'b0; wait_idle(); en_HBTX = 1'b1;
    hopsfromCH = 16'hFFFE; req(); wait_idle();
    // no CH known
    hopsfromCH = 16'hFFFF; req(); wait_idle();
    // request while disabled is ignored silently
    is_CH = 1'b1; en_HBTX = 1'b0; req(); en_HBTX = 1'b1;
    // backpressure, inputs scrambled and a stray request mid-packet
    bp_mode = 1'b1; req();
    node_ID = 16'hBEEF; node_QValue = 16'h5555; is_CH = 1'b0;
    @(posedge clk); #1 send_req = 1'b1;
    @(posedge clk); #1 send_req = 1'b0;
    wait_idle(); bp_mode = 1'b0;
    is_CH = 1'b1; node_ID = 16'h0007; node_QValue = 16'h0123;

    // per-round budget
    pulse_rr(); HB_limit = 16'd2;
    req(); wait_idle(); req(); wait_idle(); req(); wait_idle();
    HB_limit = 16'd1; req(); wait_idle();
    HB_limit = 16'd0; pulse_rr(); req(); wait_idle();
    HB_limit = 16'd2; req(); wait_idle();

    // round boundary coincident with DONE
    HB_limit = 16'hFFFF; req();
    begin
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!(pkt_valid && pkt_last && pkt_ready) && n < 50);
      if (n >= 50) tmo = 1'b1;
    end
    @(posedge clk); #1 round_reset = 1'b1;
    @(posedge clk); #1 round_reset = 1'b0;
    wait_idle();

    // reset mid-packet after word 2, then restart from seq 0
    node_QValue = 16'h0A0A; req();
    begin
      int n = 0;
      while (rd_ptr % 5 != 3 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) tmo = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    req(); wait_idle();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
